switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
//   Conditions raw slide-switch inputs before the LED-control stage uses them as sw[].
//   Per channel: 2-flop synchroniser, then a debounce counter.
//   Outputs a clean debounced level plus one-cycle rise/fall pulses.
//   Sits between the board switch pins and the LED blink/mode logic.
// PARAMETERS
//   WIDTH            2          number of independent switch channels
//   DEBOUNCE_CYCLES  2500000    stable cycles needed before a level is accepted
//                               (20 ms at 125 MHz); legal range >= 1
//   CNT_W            $clog2(DEBOUNCE_CYCLES+1)  counter width (derived, localparam)
// PORTS
//   clk      in   1      system clock, 125 MHz
//   rst      in   1      asynchronous, active-high reset
//   sw_raw   in   WIDTH  raw switch pins, asynchronous to clk
//   sw_db    out  WIDTH  debounced switch level (registered)
//   sw_rise  out  WIDTH  1-cycle pulse when sw_db[i] goes 0->1
//   sw_fall  out  WIDTH  1-cycle pulse when sw_db[i] goes 1->0
//   sw_chg   out  1      1-cycle pulse: OR of all sw_rise|sw_fall bits
// BEHAVIOUR
//   Reset:
//     - rst=1 asynchronously clears sync1, sync2, sw_db, all counters, sw_rise, sw_fall, sw_chg to 0.
//     - Reset may assert at any cycle, including mid-count; all in-progress counts are discarded.
//   Synchroniser: sync1[i] <= sw_raw[i]; sync2[i] <= sync1[i]. Only sync2 feeds the debounce logic.
//   Per channel i, on each rising edge of clk, exactly one of:
//     - sync2==sw_db: cnt <= 0.
//     - sync2!=sw_db and cnt==DEBOUNCE_CYCLES-1: sw_db <= sync2; cnt <= 0;
//       the matching sw_rise or sw_fall is 1 for the next cycle.
//     - otherwise: cnt <= cnt+1 (no saturation needed; the prior case bounds cnt).
//   Pulses:
//     - sw_rise/sw_fall are registered and high for exactly one cycle, aligned with the new sw_db value.
//     - sw_chg is registered and asserts in the same cycle as the pulses.
//   Latency: take the first edge that samples a new stable sw_raw value as edge 1.
//     - sw_db changes at edge DEBOUNCE_CYCLES+2.
//     - Example: DEBOUNCE_CYCLES=4 gives edge 6.
//   Bounce: any return of sync2 to the sw_db value before acceptance clears cnt. Counting restarts from 0.
//   Channels are fully independent.
//     - Simultaneous changes on several channels each pulse their own bit.
//     - sw_chg is a single pulse for that cycle.
//   A switch held at 1 through reset gives sw_db=0 after reset.
//     - sw_db rises after DEBOUNCE_CYCLES+2 edges, with a sw_rise pulse.
//   No combinational path from sw_raw to any output.
// TESTING (bench overrides DEBOUNCE_CYCLES=4, WIDTH=2)
//   1. rst pulse mid-cycle with sw_raw=2'b00 -> all outputs 0 immediately (async), remain 0 for 20 cycles.
//   2. sw_raw[0] 0->1 held -> sw_db[0]=1 at edge 6; sw_rise[0]=1 and sw_chg=1 for exactly that one cycle.
//   3. sw_raw[1] toggles 1,0,1,0 every 2 cycles, then holds 1 -> no sw_db[1] change during bounce;
//      sw_db[1] rises 6 edges after the final hold.
//   4. Both channels 1->0 on the same edge -> sw_fall=2'b11 and single sw_chg pulse at edge 6; sw_db=2'b00.
//   5. sw_raw=2'b01 held through rst release -> sw_db[0] rises 6 edges after release; sw_rise[0] pulse.
//   6. rst asserted at cnt=3 during a 0->1 change, then released with input still 1
//      -> full 6-edge latency restarts from 0.

Source files
------------

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//   Conditions raw slide-switch pins before the LED-control logic uses them.
//   Each channel is handled on its own:
//     - a 2-flop synchroniser brings the asynchronous pin into the clk domain;
//     - a debounce counter accepts a new level only after it has been stable
//       for DEBOUNCE_CYCLES consecutive clocks.
//   Along with the clean level, the block produces registered one-cycle
//   rise/fall pulses per channel and a combined change pulse.
//
// Ports
//   clk      in   1      system clock (125 MHz on the board)
//   rst      in   1      asynchronous, active-high reset
//   sw_raw   in   WIDTH  raw switch pins, asynchronous to clk
//   sw_db    out  WIDTH  debounced switch level (registered)
//   sw_rise  out  WIDTH  one-cycle pulse when sw_db[i] goes 0->1
//   sw_fall  out  WIDTH  one-cycle pulse when sw_db[i] goes 1->0
//   sw_chg   out  1      one-cycle pulse, OR of every sw_rise/sw_fall bit
// -----------------------------------------------------------------------------
module switch_debouncer #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 2500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_chg
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] accept;
    logic [CNT_W-1:0] cnt [WIDTH];

    // A channel accepts its new level on the edge where the differing
    // synchronised input has already been seen DEBOUNCE_CYCLES-1 times.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (sync2[i] != sw_db[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            sw_db   <= '0;
            sw_rise <= '0;
            sw_fall <= '0;
            sw_chg  <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;

            // Pulses are registered from the same accept term that updates
            // sw_db, so they line up with the first cycle of the new level.
            sw_rise <= accept & sync2;
            sw_fall <= accept & ~sync2;
            sw_chg  <= |accept;

            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == sw_db[i]) begin
                    // Input agrees with the accepted level (or bounced back).
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    sw_db[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    // Cannot overflow: the accept branch resets at CNT_LAST.
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
//   Testbench for switch_debouncer with DEBOUNCE_CYCLES=4, WIDTH=2.
//   Expected per-edge output vectors {sw_db, sw_rise, sw_fall, sw_chg} are
//   pushed to a queue as each scenario's stimulus is planned, then popped and
//   compared one per clock edge, sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_switch_debouncer;

    localparam int WIDTH = 2;
    localparam int DBC   = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_db;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_chg;

    logic [6:0] obs;
    logic [6:0] exp_v;
    logic [6:0] exp_q[$];
    logic [1:0] sched[$];

    int n_checks = 0;
    int n_fail   = 0;

    assign obs = {sw_db, sw_rise, sw_fall, sw_chg};

    switch_debouncer #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(DBC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_raw(sw_raw),
        .sw_db(sw_db),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .sw_chg(sw_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Push n copies of one expected vector {db, rise, fall, chg}, each paired
    // with the sw_raw value to drive before that edge.
    task automatic plan(input int n, input logic [1:0] raw, input logic [1:0] db,
                        input logic [1:0] rise, input logic [1:0] fall, input logic chg);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({db, rise, fall, chg});
            sched.push_back(raw);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        sw_raw = 2'b00;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_async: got %b expected %b", obs, 7'b0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        plan(20, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        while (exp_q.size() > 0) begin
            sw_raw = sched.pop_front();
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_hold: got %b expected %b", obs, exp_v);
            end
        end
    endtask

    task automatic test_rise();
        plan(5, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        plan(1, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1);
        plan(2, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        while (exp_q.size() > 0) begin
            sw_raw = sched.pop_front();
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rise_ch0: got %b expected %b", obs, exp_v);
            end
        end
    endtask

    task automatic test_bounce();
        // Channel 1 toggles 1,0,1,0 for two edges each, then holds 1.
        plan(2, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0);
        plan(2, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        plan(2, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0);
        plan(2, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        plan(5, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0);
        plan(1, 2'b11, 2'b11, 2'b10, 2'b00, 1'b1);
        plan(2, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
        while (exp_q.size() > 0) begin
            sw_raw = sched.pop_front();
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL bounce_ch1: got %b expected %b", obs, exp_v);
            end
        end
    endtask

    task automatic test_simultaneous_fall();
        plan(5, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
        plan(1, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1);
        plan(2, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        while (exp_q.size() > 0) begin
            sw_raw = sched.pop_front();
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL both_fall: got %b expected %b", obs, exp_v);
            end
        end
    endtask

    task automatic test_held_through_reset();
        sw_raw = 2'b01;
        rst    = 1'b1;
        #1;
        n_checks++;
        if (obs !== 7'b0) begin
            n_fail++;
            $display("FAIL held_reset_async: got %b expected %b", obs, 7'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        plan(5, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        plan(1, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1);
        plan(2, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        while (exp_q.size() > 0) begin
            sw_raw = sched.pop_front();
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL held_release: got %b expected %b", obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        // Channel 1 rises; after edge 5 its counter holds 3, one short of accept.
        plan(5, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0);
        while (exp_q.size() > 0) begin
            sw_raw = sched.pop_front();
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL midcount_pre: got %b expected %b", obs, exp_v);
            end
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 7'b0) begin
            n_fail++;
            $display("FAIL midcount_async: got %b expected %b", obs, 7'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        plan(5, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        plan(1, 2'b11, 2'b11, 2'b11, 2'b00, 1'b1);
        plan(2, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
        while (exp_q.size() > 0) begin
            sw_raw = sched.pop_front();
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL midcount_restart: got %b expected %b", obs, exp_v);
            end
        end
    endtask

    initial begin
        rst    = 1'b0;
        sw_raw = 2'b00;
        test_reset();
        test_rise();
        test_bounce();
        test_simultaneous_fall();
        test_held_through_reset();
        test_reset_mid_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
